// File: rtl/ccff_loader_pkg.sv
// Shared types for the configuration-chain loader: controller states and a word-count helper.
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StShift,
      StDone
   } state_e;

   // Number of stream words needed to cover a chain of num bits with den-bit words.
   function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/ccff_ser.sv
// Parallel-load, MSB-first shift register with its own bit-in-word counter.
module ccff_ser #(
   parameter int unsigned WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [WORD_W-1:0] data_i,
   input  logic              shift_i,
   output logic              ser_out_o,
   output logic              last_bit_o
);

   localparam int unsigned WbW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   logic [WORD_W-1:0] sreg_q, sreg_d;
   logic [WbW-1:0]    word_bit_q, word_bit_d;

   always_comb begin
      sreg_d     = sreg_q;
      word_bit_d = word_bit_q;
      if (load_i) begin
         sreg_d     = data_i;
         word_bit_d = '0;
      end else if (shift_i) begin
         sreg_d     = sreg_q << 1;
         word_bit_d = word_bit_q + WbW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q     <= '0;
         word_bit_q <= '0;
      end else begin
         sreg_q     <= sreg_d;
         word_bit_q <= word_bit_d;
      end
   end

   assign ser_out_o  = sreg_q[WORD_W-1];
   assign last_bit_o = (word_bit_q == WbW'(WORD_W - 1));

endmodule

// File: rtl/ccff_config_loader.sv
// Streams bitstream words MSB-first onto the fabric configuration chain, CHAIN_LEN bits per load.
module ccff_config_loader
   import ccff_loader_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 20,
   parameter int unsigned WORD_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              tail_last
);

   localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
   logic            tail_last_q, tail_last_d;
   logic            ser_out, last_bit, final_bit, ser_load, ser_shift, start_ok;

   assign final_bit = (bit_cnt_q == CntW'(CHAIN_LEN - 1));
   assign start_ok  = start && ((state_q == StIdle) || (state_q == StDone));
   assign ser_load  = (state_q == StLoad) && in_valid;
   assign ser_shift = (state_q == StShift);

   ccff_ser #(
      .WORD_W(WORD_W)
   ) u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (ser_load),
      .data_i    (in_data),
      .shift_i   (ser_shift),
      .ser_out_o (ser_out),
      .last_bit_o(last_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  if (in_valid) state_d = StShift;
            StShift: begin
               // Chain length wins over word boundary: leftover bits of the last word are dropped.
               if (final_bit) begin
                  state_d = StDone;
               end else if (last_bit) begin
                  state_d = StLoad;
               end
            end
            StDone:  if (start) state_d = StLoad;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      tail_last_d = tail_last_q;
      if (!abort) begin
         if (start_ok) begin
            bit_cnt_d = '0;
         end else if (state_q == StShift) begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
            if (final_bit) begin
               tail_last_d = ccff_tail;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_q   <= '0;
         tail_last_q <= 1'b0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         tail_last_q <= tail_last_d;
      end
   end

   always_comb begin
      in_ready      = (state_q == StLoad);
      ccff_shift_en = (state_q == StShift);
      ccff_head     = (state_q == StShift) && ser_out;
      busy          = (state_q == StLoad) || (state_q == StShift);
      done          = (state_q == StDone);
      tail_last     = tail_last_q;
   end

endmodule

// File: tb/tb_ccff_config_loader.sv
// Directed bench for ccff_config_loader: a 20-bit/8-bit chain and a 16-bit/8-bit chain.
module tb_ccff_config_loader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_a, start_b, abort_a, abort_b;
   logic [7:0] in_data;
   logic       in_valid;
   logic       tail_a, tail_b;
   logic       rdy_a, head_a, sh_a, busy_a, done_a, tl_a;
   logic       rdy_b, head_b, sh_b, busy_b, done_b, tl_b;

   int          n_cmp = 0;
   int          n_err = 0;
   int          pulses_a = 0, pulses_b = 0, words_a = 0, words_b = 0;
   logic [63:0] seq_a = '0, seq_b = '0;
   logic [7:0]  words [3];

   always #5 clk = ~clk;

   ccff_config_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .in_data(in_data),
      .in_valid(in_valid), .in_ready(rdy_a), .ccff_head(head_a), .ccff_shift_en(sh_a),
      .ccff_tail(tail_a), .busy(busy_a), .done(done_a), .tail_last(tl_a)
   );

   ccff_config_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .in_data(in_data),
      .in_valid(in_valid), .in_ready(rdy_b), .ccff_head(head_b), .ccff_shift_en(sh_b),
      .ccff_tail(tail_b), .busy(busy_b), .done(done_b), .tail_last(tl_b)
   );

   // Chain-side observer: what the fabric would capture, and which words the host saw taken.
   always @(posedge clk) begin
      if (sh_a) begin
         pulses_a <= pulses_a + 1;
         seq_a    <= {seq_a[62:0], head_a};
      end
      if (sh_b) begin
         pulses_b <= pulses_b + 1;
         seq_b    <= {seq_b[62:0], head_b};
      end
      if (in_valid && rdy_a) words_a <= words_a + 1;
      if (in_valid && rdy_b) words_b <= words_b + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input bit sel);
      @(negedge clk);
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      check("ready_after_start", sel ? rdy_b : rdy_a, 1);
   endtask

   // Feeds words until done; drives tail=1 only on the final pulse; optional stall and stray start.
   task automatic feed(input bit sel, input int nwords, input int stall_len, input int start_at,
                       output int cycles, output bit stall_bad);
      int idx, stall, p0;
      bit pend, prev_sh, cur_sh, rdy, got;
      idx = 0; stall = 0; pend = 0; prev_sh = 0; got = 0; stall_bad = 0; cycles = -1;
      p0 = sel ? pulses_b : pulses_a;
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(negedge clk);
         start_a = 1'b0;
         start_b = 1'b0;
         cur_sh  = sel ? sh_b : sh_a;
         rdy     = sel ? rdy_b : rdy_a;
         if (sel ? done_b : done_a) begin
            got    = 1;
            cycles = cyc;
            check("done_follows_last_pulse", prev_sh, 1);
            check("busy_low_at_done", sel ? busy_b : busy_a, 0);
            break;
         end
         prev_sh = cur_sh;
         tail_a  = !sel && cur_sh && (pulses_a - p0 == 19);
         tail_b  = sel && cur_sh && (pulses_b - p0 == 15);
         if (cyc == start_at) begin
            if (sel) start_b = 1'b1; else start_a = 1'b1;
         end
         if (pend && rdy) begin
            stall = stall_len;
            pend  = 0;
         end
         if (stall > 0) begin
            in_valid = 1'b0;
            if (!rdy || cur_sh) stall_bad = 1;
            stall--;
         end else if (idx < nwords) begin
            in_valid = 1'b1;
            in_data  = words[idx];
         end else begin
            in_valid = 1'b0;
         end
         if (in_valid && rdy) begin
            idx++;
            pend = (stall_len > 0);
         end
      end
      in_valid = 1'b0; tail_a = 1'b0; tail_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
      check("done_reached", got, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  p0, w0, cyc;
      bit  sbad;
      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0;
      rst_n = 1'b0; start_a = 0; start_b = 0; abort_a = 0; abort_b = 0;
      in_data = '0; in_valid = 0; tail_a = 0; tail_b = 0;

      // Reset values
      @(negedge clk);
      check("rst_in_ready", rdy_a, 0);
      check("rst_head", head_a, 0);
      check("rst_shift_en", sh_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_tail_last", tl_a, 0);
      rst_n = 1'b1;

      // Basic load, in_valid held high: 3 words, 20 pulses, done one cycle after last pulse
      do_start(0);
      p0 = pulses_a; w0 = words_a;
      feed(0, 3, 0, -1, cyc, sbad);
      check("basic_pulses", pulses_a - p0, 20);
      check("basic_head_seq", seq_a[19:0], 20'hA53CF);
      check("basic_words", words_a - w0, 3);
      check("basic_cycles", cyc, 23);
      check("basic_tail_last", tl_a, 1);

      // Host stalls 5 cycles between words
      do_start(0);
      p0 = pulses_a; w0 = words_a;
      feed(0, 3, 5, -1, cyc, sbad);
      check("stall_no_pulse_ready_held", sbad, 0);
      check("stall_pulses", pulses_a - p0, 20);
      check("stall_head_seq", seq_a[19:0], 20'hA53CF);
      check("stall_words", words_a - w0, 3);
      check("stall_cycles", cyc, 33);

      // Abort in the 3rd SHIFT cycle of word 2
      do_start(0);
      in_valid = 1'b1; in_data = 8'hA5;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 20 && !rdy_a; i++) @(negedge clk);
      check("abort_ready_word2", rdy_a, 1);
      in_valid = 1'b1; in_data = 8'h3C;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_in_shift", sh_a, 1);
      p0 = pulses_a;
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      check("abort_busy", busy_a, 0);
      check("abort_done", done_a, 0);
      check("abort_shift_en", sh_a, 0);
      check("abort_ready", rdy_a, 0);
      // in_valid while IDLE must not consume anything
      w0 = words_a;
      in_valid = 1'b1; in_data = 8'hFF;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      check("abort_no_more_pulses", pulses_a - p0, 1);
      check("idle_valid_ignored", words_a - w0, 0);

      // Reload after abort, with a stray start mid-load
      do_start(0);
      p0 = pulses_a; w0 = words_a;
      feed(0, 3, 0, 12, cyc, sbad);
      check("reload_pulses", pulses_a - p0, 20);
      check("reload_head_seq", seq_a[19:0], 20'hA53CF);
      check("reload_words", words_a - w0, 3);
      check("reload_cycles", cyc, 23);

      // Asynchronous reset mid-SHIFT
      do_start(0);
      in_valid = 1'b1; in_data = 8'hA5;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
      check("pre_reset_shifting", sh_a, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_shift_en", sh_a, 0);
      check("arst_head", head_a, 0);
      check("arst_busy", busy_a, 0);
      check("arst_ready", rdy_a, 0);
      check("arst_done", done_a, 0);
      check("arst_tail_last", tl_a, 0);
      p0 = pulses_a;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_reset_no_pulses", pulses_a - p0, 0);
      do_start(0);
      p0 = pulses_a; w0 = words_a;
      feed(0, 3, 0, -1, cyc, sbad);
      check("post_reset_pulses", pulses_a - p0, 20);
      check("post_reset_head_seq", seq_a[19:0], 20'hA53CF);
      check("post_reset_words", words_a - w0, 3);

      // 16-bit chain, whole words only; tail driven 1 on pulse 16
      do_start(1);
      p0 = pulses_b; w0 = words_b;
      feed(1, 3, 0, -1, cyc, sbad);
      check("b_pulses", pulses_b - p0, 16);
      check("b_head_seq", seq_b[15:0], 16'hA53C);
      check("b_words", words_b - w0, 2);
      check("b_tail_last", tl_b, 1);
      check("b_cycles", cyc, 18);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
